// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : run_ctrl_pkg
//  Brief    : Shared state encoding and default parameters for run_ctrl.
//  Revision : 1.0
// ============================================================================
package run_ctrl_pkg;

    localparam int unsigned CW_DEF    = 16;
    localparam int unsigned DRAIN_DEF = 1;
    localparam int unsigned TMO_DEF   = 4000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : run_ctrl_if
//  Brief    : Host/core handshake bundle for run_ctrl (master = host side).
//  Revision : 1.0
// ============================================================================
interface run_ctrl_if
    import run_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF
);
    logic          req;
    logic          halt;
    logic          core_rst;
    logic          core_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycles;
    logic          timeout;

    modport master (
        output req,
        output halt,
        input  core_rst,
        input  core_en,
        input  busy,
        input  done,
        input  cycles,
        input  timeout
    );

    modport slave (
        input  req,
        input  halt,
        output core_rst,
        output core_en,
        output busy,
        output done,
        output cycles,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/run_cycle_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : run_cycle_ctr
//  Brief    : Saturating run-cycle counter with sync clear; the watchdog
//             compare port exists only when RUN_CTRL_WATCHDOG_EN is defined.
//  Revision : 1.0
// ============================================================================
module run_cycle_ctr #(
    parameter int CW    = 16
`ifdef RUN_CTRL_WATCHDOG_EN
    ,
    parameter int LIMIT = 4000
`endif
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          clr_i,
    input  wire logic          en_i,
    output logic      [CW-1:0] count_o
`ifdef RUN_CTRL_WATCHDOG_EN
    ,
    output logic               expire_o
`endif
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

`ifdef RUN_CTRL_WATCHDOG_EN
    // True during the last RUN cycle before the count would reach LIMIT.
    assign expire_o = (count_q == CW'(LIMIT - 1));
`endif

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : run_ctrl
//  Brief    : Run sequencer: IDLE/CLEAR/RUN/DRAIN/DONE with registered Moore
//             outputs; optional watchdog via RUN_CTRL_WATCHDOG_EN.
//  Revision : 1.0
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int DRAIN = DRAIN_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  wire logic clk,
    input  wire logic reset,
    run_ctrl_if.slave bus
);

    localparam logic [2:0] DRAIN_LD = 3'(DRAIN);

    run_state_t    state_q, state_d;
    logic [2:0]    drain_q, drain_d;
    logic          core_rst_q, core_rst_d;
    logic          core_en_q, core_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          w_ctr_clr;
    logic          w_ctr_en;
    logic          w_expire;
    logic [CW-1:0] w_cycles;

`ifdef RUN_CTRL_WATCHDOG_EN
    logic          timeout_q, timeout_d;

    run_cycle_ctr #(
        .CW    (CW),
        .LIMIT (TMO)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (w_ctr_clr),
        .en_i     (w_ctr_en),
        .count_o  (w_cycles),
        .expire_o (w_expire)
    );
`else
    run_cycle_ctr #(
        .CW (CW)
    ) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (w_ctr_clr),
        .en_i    (w_ctr_en),
        .count_o (w_cycles)
    );

    assign w_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        w_ctr_clr = 1'b0;
        w_ctr_en  = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_ctr_clr = 1'b1;
`ifdef RUN_CTRL_WATCHDOG_EN
                timeout_d = 1'b0;
`endif
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                w_ctr_en = 1'b1;
                if (bus.halt || w_expire) begin
                    if (DRAIN == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LD;
                    end
                end
`ifdef RUN_CTRL_WATCHDOG_EN
                // Halt on the expiry edge is a clean finish, not a timeout.
                timeout_d = w_expire && !bus.halt;
`endif
            end
            ST_DRAIN: begin
                if (drain_q <= 3'd1) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            ST_DONE: begin
                if (!bus.req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the current state one edge later.
        core_rst_d = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
        core_en_d  = (state_q == ST_RUN);
        busy_d     = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                     (state_q == ST_DRAIN);
        done_d     = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            drain_q    <= 3'd0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.core_rst = core_rst_q;
    assign bus.core_en  = core_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cycles   = w_cycles;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_ctrl
//  Brief    : Directed self-checking bench for run_ctrl (CW=16/DRAIN=1/TMO=20
//             instance plus a CW=4 saturation instance).
//  Revision : 1.0
// ============================================================================
module tb_run_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    run_ctrl_if #(.CW(16)) bus  ();
    run_ctrl_if #(.CW(4))  bus4 ();

    run_ctrl #(
        .CW    (16),
        .DRAIN (1),
        .TMO   (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    run_ctrl #(
        .CW    (4),
        .DRAIN (1),
        .TMO   (15)
    ) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        bus.req   = 1'b0;
        bus.halt  = 1'b0;
        bus4.req  = 1'b0;
        bus4.halt = 1'b0;
        #3;
        chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("rst_core_en",  32'(bus.core_en),  32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_cycles",   32'(bus.cycles),   32'd0);
        chk("rst_timeout",  32'(bus.timeout),  32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Basic run: req at edge 0, halt at 5th RUN edge (edge 6)
        bus.req = 1'b1;
        tick();                                   // edge 0
        chk("e0_busy",    32'(bus.busy),    32'd0);
        chk("e0_core_en", 32'(bus.core_en), 32'd0);
        tick();                                   // edge 1
        chk("e1_busy",     32'(bus.busy),     32'd1);
        chk("e1_core_rst", 32'(bus.core_rst), 32'd1);
        chk("e1_core_en",  32'(bus.core_en),  32'd0);
        tick();                                   // edge 2
        chk("e2_core_en",  32'(bus.core_en),  32'd1);
        chk("e2_core_rst", 32'(bus.core_rst), 32'd0);
        chk("e2_cycles",   32'(bus.cycles),   32'd1);
        tick();
        tick();
        tick();                                   // edge 5
        chk("e5_cycles", 32'(bus.cycles), 32'd4);
        bus.halt = 1'b1;
        tick();                                   // edge 6
        bus.halt = 1'b0;
        chk("e6_cycles",  32'(bus.cycles),  32'd5);
        chk("e6_core_en", 32'(bus.core_en), 32'd1);
        tick();                                   // edge 7
        chk("e7_core_en", 32'(bus.core_en), 32'd0);
        chk("e7_busy",    32'(bus.busy),    32'd1);
        chk("e7_done",    32'(bus.done),    32'd0);
        tick();                                   // edge 8
        chk("e8_done",     32'(bus.done),     32'd1);
        chk("e8_busy",     32'(bus.busy),     32'd0);
        chk("e8_core_rst", 32'(bus.core_rst), 32'd0);
        chk("e8_cycles",   32'(bus.cycles),   32'd5);
        chk("e8_timeout",  32'(bus.timeout),  32'd0);

        // Hold req in DONE, then release
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold_done", 32'(bus.done), 32'd1);
        end
        bus.req = 1'b0;
        tick();
        chk("rel_done_lag", 32'(bus.done),     32'd1);
        chk("rel_core_rst", 32'(bus.core_rst), 32'd0);
        tick();
        chk("idle_done",     32'(bus.done),     32'd0);
        chk("idle_core_rst", 32'(bus.core_rst), 32'd1);
        chk("idle_cycles",   32'(bus.cycles),   32'd5);

`ifdef RUN_CTRL_WATCHDOG_EN
        // Watchdog expiry with halt never asserted
        bus.req = 1'b1;
        tick();                                   // edge 0
        tick();                                   // edge 1: counter cleared
        chk("wd_clr_cycles", 32'(bus.cycles), 32'd0);
        for (int i = 0; i < 20; i++) tick();      // edges 2..21
        chk("wd_cycles",  32'(bus.cycles),  32'd20);
        chk("wd_timeout", 32'(bus.timeout), 32'd1);
        tick();
        chk("wd_done_early", 32'(bus.done), 32'd0);
        tick();
        chk("wd_done", 32'(bus.done), 32'd1);
        bus.req = 1'b0;
        tick();
        tick();
        chk("wd_idle_timeout", 32'(bus.timeout), 32'd1);

        // Halt on the expiry edge wins
        bus.req = 1'b1;
        tick();
        tick();
        chk("wd2_clr_timeout", 32'(bus.timeout), 32'd0);
        for (int i = 0; i < 19; i++) tick();      // edges 2..20
        bus.halt = 1'b1;
        tick();                                   // edge 21
        bus.halt = 1'b0;
        chk("wd2_cycles",  32'(bus.cycles),  32'd20);
        chk("wd2_timeout", 32'(bus.timeout), 32'd0);
        tick();
        tick();
        chk("wd2_done", 32'(bus.done), 32'd1);
        bus.req = 1'b0;
        tick();
        tick();
`else
        // No watchdog: run well past TMO, still busy
        bus.req = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 30; i++) tick();
        chk("nowd_busy",    32'(bus.busy),    32'd1);
        chk("nowd_cycles",  32'(bus.cycles),  32'd30);
        chk("nowd_timeout", 32'(bus.timeout), 32'd0);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        tick();
        tick();
        chk("nowd_done", 32'(bus.done), 32'd1);
        bus.req = 1'b0;
        tick();
        tick();
`endif

        // One-cycle req pulse
        bus.req = 1'b1;
        tick();                                   // edge 0
        bus.req = 1'b0;
        tick();                                   // edge 1
        chk("pulse_busy", 32'(bus.busy), 32'd1);
        tick();
        tick();
        tick();                                   // edge 4 pending
        bus.halt = 1'b1;
        tick();                                   // edge 5: 4th RUN edge
        bus.halt = 1'b0;
        chk("pulse_cycles", 32'(bus.cycles), 32'd4);
        tick();                                   // edge 6
        chk("pulse_done0", 32'(bus.done), 32'd0);
        tick();                                   // edge 7
        chk("pulse_done1", 32'(bus.done), 32'd1);
        tick();                                   // edge 8
        chk("pulse_done2", 32'(bus.done),     32'd0);
        chk("pulse_idle",  32'(bus.core_rst), 32'd1);

        // Async reset mid-RUN at cycles=7
        bus.req = 1'b1;
        tick();                                   // edge 0
        for (int i = 0; i < 8; i++) tick();       // edges 1..8
        chk("pre_rst_cycles", 32'(bus.cycles), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_core_en",  32'(bus.core_en),  32'd0);
        chk("arst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("arst_cycles",   32'(bus.cycles),   32'd0);
        chk("arst_busy",     32'(bus.busy),     32'd0);
        #1;
        reset = 1'b0;
        tick();                                   // IDLE -> CLEAR
        chk("restart_busy0", 32'(bus.busy), 32'd0);
        tick();
        chk("restart_busy1",    32'(bus.busy),     32'd1);
        chk("restart_core_rst", 32'(bus.core_rst), 32'd1);
        tick();
        chk("restart_core_en", 32'(bus.core_en), 32'd1);
        chk("restart_cycles",  32'(bus.cycles),  32'd1);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("restart_cycles2", 32'(bus.cycles), 32'd2);
        bus.req = 1'b0;
        tick();
        tick();
        chk("restart_done", 32'(bus.done), 32'd1);
        tick();
        chk("restart_idle", 32'(bus.done), 32'd0);

        // CW=4 saturation
        bus4.req = 1'b1;
        tick();                                   // edge 0
        tick();                                   // edge 1
`ifdef RUN_CTRL_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick();      // edges 2..16
        chk("sat_cycles",  32'(bus4.cycles),  32'd15);
        chk("sat_timeout", 32'(bus4.timeout), 32'd1);
`else
        for (int i = 0; i < 15; i++) tick();      // edges 2..16
        chk("sat_at15", 32'(bus4.cycles), 32'd15);
        for (int i = 0; i < 4; i++) tick();       // edges 17..20
        bus4.halt = 1'b1;
        tick();                                   // edge 21: 20th RUN edge
        bus4.halt = 1'b0;
        chk("sat_cycles",  32'(bus4.cycles),  32'd15);
        chk("sat_timeout", 32'(bus4.timeout), 32'd0);
`endif
        tick();
        tick();
        chk("sat_done", 32'(bus4.done), 32'd1);
        bus4.req = 1'b0;
        tick();
        tick();
        chk("sat_idle_cycles", 32'(bus4.cycles), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
# run_ctrl

Run sequencer for the single-cycle core. It accepts a four-phase start request from the host or bench, and holds the core in clear while idle. It then enables the core until the core reports halt or a watchdog expires, drains in-flight writes, and signals done. It sits between the top-level `req`/`done` pins and the core's PC enable and synchronous clear. It also keeps a cycle count for the run.

## Interface
Parameters:
- `CW`, 16: cycle counter width.
- `DRAIN`, 1: cycles the core stays stalled after halt before done; range 0..7.
- `TMO`, 4000: watchdog limit in RUN cycles; used only when the watchdog is compiled in; must be < 2^CW.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, 1: start request level from the host.
- `halt`, in, 1: core end-of-program flag (PC reached end address); combinational from the core.
- `core_rst`, out, 1: synchronous clear to the PC and flag registers.
- `core_en`, out, 1: PC advance / register-write enable.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run complete; held high for the acknowledge phase.
- `cycles`, out, CW: RUN cycles of the last or current run.
- `timeout`, out, 1: last run ended by the watchdog.

## Operation
- States are IDLE, CLEAR, RUN, DRAIN, DONE. All outputs are registered (Moore).
- Reset values: state IDLE, `core_rst`=1, `core_en`=0, `busy`=0, `done`=0, `cycles`=0, `timeout`=0.
- IDLE:
  - `core_rst`=1, `core_en`=0.
  - `req`=1 → CLEAR.
- CLEAR (exactly 1 cycle):
  - `core_rst`=1, `busy`=1.
  - `cycles`←0, `timeout`←0.
  - `halt` is ignored.
  - → RUN.
- RUN:
  - `core_en`=1, `core_rst`=0, `busy`=1.
  - `cycles` increments every edge and saturates at all-ones.
  - `halt`=1 → DRAIN, or DONE if DRAIN=0.
- DRAIN:
  - `core_en`=0, `busy`=1.
  - A down-counter loaded with DRAIN on entry; → DONE when it reaches 1.
- DONE:
  - `done`=1, `busy`=0, `core_en`=0.
  - `core_rst` stays 0 so the bench can inspect core state.
  - `req`=0 → IDLE.
- `req` falling during CLEAR/RUN/DRAIN is ignored; the run completes. DONE with `req` already low lasts exactly 1 cycle.
- A new run requires `req` to be low in DONE first. There is no retrigger from DONE.
- `cycles` and `timeout` hold from DONE through IDLE until the next CLEAR.
- Asserting `reset` mid-run forces the reset values immediately. It does not wait for a clock edge.

## Timing
- `req` sampled high at edge t: CLEAR during cycle t..t+1, `core_en`=1 from edge t+2.
- If `halt` is sampled high at the k-th RUN edge, then `cycles`=k. The halting instruction's write completes on that edge.
- With DRAIN=1, `halt` at edge h gives DRAIN in cycle h..h+1 and `done`=1 from edge h+2. In general `done` rises DRAIN+1 edges after `halt`.
- `done` falls 1 edge after `req` is sampled low.
- Start-to-first-fetch latency is fixed at 2 cycles.

## Configuration
- Macro `RUN_CTRL_WATCHDOG_EN`.
- Defined:
  - In RUN, `halt`=0 at the edge where `cycles`=TMO-1 → DRAIN with `timeout`←1.
  - `halt` and expiry on the same edge: halt wins, `timeout`=0.
- Undefined:
  - No watchdog. RUN lasts until `halt`.
  - `timeout` is tied to 0 and `TMO` is unused.

## Structure
- Shared package `run_ctrl_pkg`:
  - state enum `run_state_t` (IDLE, CLEAR, RUN, DRAIN, DONE)
  - default constants for `CW`, `DRAIN`, `TMO`
- One sub-module, `run_cycle_ctr`: a CW-bit saturating counter with synchronous clear and enable, reset to 0. It produces `cycles` and the watchdog compare.
- The FSM, drain counter and output registers stay in `run_ctrl`.

## Test plan
- Reset then `req`=1 at edge 0, `halt`=1 at the 5th RUN edge (DRAIN=1) → `core_en` high edges 2..6, `done` rises at edge 8, `cycles`=5, `timeout`=0.
- Hold `req` high in DONE for 10 cycles, then drop it → `done` stays high 10 cycles, falls 1 edge after `req` is sampled low; `cycles` still reads 5 in IDLE.
- Watchdog on, TMO=20, `halt` never asserted → `timeout`=1, `cycles`=20, `done` 2 edges after expiry. Repeat with `halt` at the 20th edge → `timeout`=0.
- Pulse `req` for 1 cycle only → the run completes normally; `done` is high for exactly 1 cycle, then IDLE.
- Assert `reset` asynchronously mid-RUN at `cycles`=7 → `core_en`=0 and `core_rst`=1 immediately, `cycles`=0, state IDLE; a new run restarts from CLEAR.
- CW=4, `halt` after 20 RUN edges → `cycles` saturates at 15.
